// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one transaction at a time.
// Define MEMARB_RR_EN for round-robin grants; otherwise data has priority and a starvation counter bounds fetch wait.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req_valid,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_req_ready,
    output logic          if_rsp_valid,
    output logic [31:0]   if_rsp_data,
    input  logic          d_req_valid,
    input  logic          d_req_we,
    input  logic [AW-1:0] d_req_addr,
    input  logic [31:0]   d_req_wdata,
    input  logic [3:0]    d_req_be,
    output logic          d_req_ready,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rsp_data,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          mem_ren,
    output logic          mem_wren,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          lat_done_s;
    logic          can_accept_s;
    logic          grant_d_s;
    logic          d_ready_s;
    logic          if_ready_s;
    logic          d_acc_s;
    logic          if_acc_s;
    logic          acc_s;

    logic          owner_d_r;
    logic          owner_we_r;
    logic [2:0]    lat_cnt_r;
    logic [AW-1:0] mem_addr_r;
    logic [31:0]   mem_wdata_r;
    logic [3:0]    mem_be_r;
    logic          mem_ren_r;
    logic          mem_wren_r;
    logic          if_rsp_valid_r;
    logic [31:0]   if_rsp_data_r;
    logic          d_rsp_valid_r;
    logic [31:0]   d_rsp_data_r;
    logic          busy_r;

`ifdef MEMARB_RR_EN
    logic          last_d_r;

    // Round-robin choice: on a tie the requester not granted last wins
    always_comb begin
        grant_d_s = 1'b0;
        if (d_req_valid && if_req_valid) begin
            grant_d_s = !last_d_r;
        end else if (d_req_valid) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Last-grant history; starts as fetch so data wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_r <= 1'b0;
        end else if (acc_s) begin
            last_d_r <= d_acc_s;
        end
    end
`else
    logic [3:0]    starve_cnt_r;

    // Fixed priority choice: data wins a tie unless fetch has waited STARVE_MAX cycles
    always_comb begin
        grant_d_s = 1'b0;
        if (d_req_valid && if_req_valid) begin
            grant_d_s = (starve_cnt_r != 4'(STARVE_MAX));
        end else if (d_req_valid) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Saturating count of fetch cycles spent waiting, cleared when fetch is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (if_acc_s) begin
            starve_cnt_r <= 4'd0;
        end else if (if_req_valid && !if_ready_s && (starve_cnt_r != 4'(STARVE_MAX))) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end
    end
`endif

    // Acceptance window: only IDLE or the RESP cycle, never while reset is asserted
    always_comb begin
        can_accept_s = 1'b0;
        if (!reset && ((state_r == ST_IDLE) || (state_r == ST_RESP))) begin
            can_accept_s = 1'b1;
        end else begin
            can_accept_s = 1'b0;
        end
    end

    assign d_ready_s  = can_accept_s && grant_d_s;
    assign if_ready_s = can_accept_s && if_req_valid && !grant_d_s;
    assign d_acc_s    = d_req_valid && d_ready_s;
    assign if_acc_s   = if_req_valid && if_ready_s;
    assign acc_s      = d_acc_s || if_acc_s;

    // Next-state decode; lat_done_s marks the cycle mem_rdata is valid
    always_comb begin
        state_s    = state_r;
        lat_done_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (acc_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (owner_we_r) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r == 3'(MEM_LAT - 1)) begin
                    lat_done_s = 1'b1;
                    state_s    = ST_RESP;
                end else begin
                    state_s    = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture, memory strobes, latency count and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_d_r      <= 1'b0;
            owner_we_r     <= 1'b0;
            lat_cnt_r      <= 3'd0;
            mem_addr_r     <= '0;
            mem_wdata_r    <= 32'h0;
            mem_be_r       <= 4'h0;
            mem_ren_r      <= 1'b0;
            mem_wren_r     <= 1'b0;
            if_rsp_valid_r <= 1'b0;
            if_rsp_data_r  <= 32'h0;
            d_rsp_valid_r  <= 1'b0;
            d_rsp_data_r   <= 32'h0;
            busy_r         <= 1'b0;
        end else begin
            mem_ren_r  <= if_acc_s || (d_acc_s && !d_req_we);
            mem_wren_r <= d_acc_s && d_req_we;
            if (d_acc_s) begin
                mem_addr_r  <= d_req_addr;
                mem_wdata_r <= d_req_wdata;
                mem_be_r    <= d_req_be;
                owner_d_r   <= 1'b1;
                owner_we_r  <= d_req_we;
            end else if (if_acc_s) begin
                mem_addr_r  <= if_req_addr;
                mem_be_r    <= 4'b1111;
                owner_d_r   <= 1'b0;
                owner_we_r  <= 1'b0;
            end
            if (state_r == ST_ISSUE) begin
                lat_cnt_r <= 3'd0;
            end else if (state_r == ST_WAIT) begin
                lat_cnt_r <= lat_cnt_r + 3'd1;
            end
            if (lat_done_s && owner_d_r) begin
                d_rsp_data_r <= mem_rdata;
            end
            if (lat_done_s && !owner_d_r) begin
                if_rsp_data_r <= mem_rdata;
            end
            if ((state_r == ST_ISSUE) && owner_we_r) begin
                d_rsp_data_r <= 32'h0;
            end
            if_rsp_valid_r <= (state_s == ST_RESP) && !owner_d_r;
            d_rsp_valid_r  <= (state_s == ST_RESP) && owner_d_r;
            busy_r         <= (state_s != ST_IDLE);
        end
    end

    assign if_req_ready = if_ready_s;
    assign d_req_ready  = d_ready_s;
    assign if_rsp_valid = if_rsp_valid_r;
    assign if_rsp_data  = if_rsp_data_r;
    assign d_rsp_valid  = d_rsp_valid_r;
    assign d_rsp_data   = d_rsp_data_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign mem_be       = mem_be_r;
    assign mem_ren      = mem_ren_r;
    assign mem_wren     = mem_wren_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model checked every cycle plus directed literals.
// A second instance with MEM_LAT=3 checks long-latency back-to-back timing.
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_be;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ren;
    logic        mem_wren;
    logic [31:0] mem_rdata;
    logic        busy;

    logic        l3_if_valid;
    logic [31:0] l3_if_addr;
    logic        l3_if_ready;
    logic        l3_if_rsp_valid;
    logic [31:0] l3_if_rsp_data;
    logic        l3_d_valid;
    logic        l3_d_we;
    logic [31:0] l3_d_addr;
    logic [31:0] l3_d_wdata;
    logic [3:0]  l3_d_be;
    logic        l3_d_ready;
    logic        l3_d_rsp_valid;
    logic [31:0] l3_d_rsp_data;
    logic [31:0] l3_mem_addr;
    logic [31:0] l3_mem_wdata;
    logic [3:0]  l3_mem_be;
    logic        l3_mem_ren;
    logic        l3_mem_wren;
    logic [31:0] l3_mem_rdata;
    logic        l3_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ren(mem_ren), .mem_wren(mem_wren), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
        .clk(clk), .reset(reset),
        .if_req_valid(l3_if_valid), .if_req_addr(l3_if_addr), .if_req_ready(l3_if_ready),
        .if_rsp_valid(l3_if_rsp_valid), .if_rsp_data(l3_if_rsp_data),
        .d_req_valid(l3_d_valid), .d_req_we(l3_d_we), .d_req_addr(l3_d_addr),
        .d_req_wdata(l3_d_wdata), .d_req_be(l3_d_be), .d_req_ready(l3_d_ready),
        .d_rsp_valid(l3_d_rsp_valid), .d_rsp_data(l3_d_rsp_data),
        .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_be(l3_mem_be),
        .mem_ren(l3_mem_ren), .mem_wren(l3_mem_wren), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: one transaction at a time, fixed cycle offsets from acceptance.
    int          next_free = 0;
    int          acc_cyc   = -1;
    int          iss_cyc   = -1;
    int          rsp_cyc   = -1;
    bit          own_d     = 1'b0;
    bit          own_we    = 1'b0;
    logic [31:0] exp_addr  = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [3:0]  exp_be    = 4'h0;
    int          starve    = 0;
    bit          last_d    = 1'b0;
    logic [31:0] hist [64];

    always @(negedge clk) begin : model
        bit can, fetch_pref, gd, e_d_rdy, e_if_rdy, a_d, a_if;
        logic [31:0] e_data;
        hist[cyc % 64] = mem_rdata;
        can = (cyc >= next_free);
`ifdef MEMARB_RR_EN
        fetch_pref = last_d;
`else
        fetch_pref = (starve == SMAX);
`endif
        gd       = d_req_valid && !(if_req_valid && fetch_pref);
        e_d_rdy  = can && gd;
        e_if_rdy = can && if_req_valid && !gd;
        if (!reset) begin
            check("d_req_ready", d_req_ready, e_d_rdy);
            check("if_req_ready", if_req_ready, e_if_rdy);
        end
        check("mem_ren", mem_ren, (cyc == iss_cyc) && !own_we);
        check("mem_wren", mem_wren, (cyc == iss_cyc) && own_we);
        check("mem_addr", mem_addr, exp_addr);
        if ((cyc == iss_cyc) && own_d) begin
            check("mem_wdata", mem_wdata, exp_wdata);
            check("mem_be", 32'(mem_be), 32'(exp_be));
        end
        check("if_rsp_valid", if_rsp_valid, (cyc == rsp_cyc) && !own_d);
        check("d_rsp_valid", d_rsp_valid, (cyc == rsp_cyc) && own_d);
        if (cyc == rsp_cyc) begin
            e_data = own_we ? 32'h0 : hist[(iss_cyc + LAT) % 64];
            if (own_d) check("d_rsp_data", d_rsp_data, e_data);
            else       check("if_rsp_data", if_rsp_data, e_data);
        end
        check("busy", busy, (cyc > acc_cyc) && (cyc <= rsp_cyc));

        if (reset) begin
            next_free = cyc + 1;
            acc_cyc   = -1;
            iss_cyc   = -1;
            rsp_cyc   = -1;
            exp_addr  = 32'h0;
            starve    = 0;
            last_d    = 1'b0;
        end else begin
            a_d  = d_req_valid && e_d_rdy;
            a_if = if_req_valid && e_if_rdy;
            if (a_d || a_if) begin
                acc_cyc   = cyc;
                iss_cyc   = cyc + 1;
                own_d     = a_d;
                own_we    = a_d && d_req_we;
                rsp_cyc   = own_we ? cyc + 2 : cyc + 2 + LAT;
                next_free = rsp_cyc;
                exp_addr  = a_d ? d_req_addr : if_req_addr;
                if (a_d) begin
                    exp_wdata = d_req_wdata;
                    exp_be    = d_req_be;
                end
                last_d = a_d;
            end
            if (a_if) starve = 0;
            else if (if_req_valid && !e_if_rdy && starve < SMAX) starve = starve + 1;
        end
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  seq;
        logic [12:0] ren_mask, rsp_mask;
        int ng, first_f, t, n3;
        bit acc_if_seen, acc_d_seen;

        reset = 1'b1;
        if_req_valid = 1'b0; if_req_addr = 32'h0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0; d_req_be = 4'h0;
        mem_rdata = 32'h0;
        l3_if_valid = 1'b0; l3_if_addr = 32'h0;
        l3_d_valid = 1'b0; l3_d_we = 1'b0; l3_d_addr = 32'h0; l3_d_wdata = 32'h0; l3_d_be = 4'hf;
        l3_mem_rdata = 32'h0;
        repeat (3) step();

        // Fetch only after reset, next fetch taken in the RESP cycle
        reset = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h01000000; mem_rdata = 32'hfd010113;
        @(negedge clk); check("t1_ready_c0", if_req_ready, 1'b1);
        step(); if_req_addr = 32'h01000004;
        @(negedge clk); check("t1_ren_c1", mem_ren, 1'b1); check("t1_addr_c1", mem_addr, 32'h01000000);
        step(); step();
        @(negedge clk);
        check("t1_rsp_valid_c3", if_rsp_valid, 1'b1);
        check("t1_rsp_data_c3", if_rsp_data, 32'hfd010113);
        check("t1_next_ready_c3", if_req_ready, 1'b1);
        step(); if_req_valid = 1'b0;
        repeat (3) step();

        // Store
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h01000100;
        d_req_wdata = 32'hdeadbeef; d_req_be = 4'b1111;
        @(negedge clk); check("t2_ready", d_req_ready, 1'b1);
        step(); d_req_valid = 1'b0;
        @(negedge clk);
        check("t2_wren", mem_wren, 1'b1); check("t2_ren", mem_ren, 1'b0);
        check("t2_addr", mem_addr, 32'h01000100); check("t2_wdata", mem_wdata, 32'hdeadbeef);
        check("t2_be", 32'(mem_be), 32'h0000000f);
        step();
        @(negedge clk); check("t2_rsp_valid", d_rsp_valid, 1'b1); check("t2_rsp_data", d_rsp_data, 32'h0);
        step();

        // Both requesters continuously valid: record the first four grants
        if_req_valid = 1'b1; if_req_addr = 32'h01000010;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h00002000; d_req_be = 4'b1111;
        seq = 4'h0; ng = 0; first_f = -1; t = 0;
        while (ng < 4 && t < 100) begin
            @(negedge clk);
            acc_d_seen  = d_req_valid && d_req_ready;
            acc_if_seen = if_req_valid && if_req_ready;
            if (acc_d_seen) begin
                seq[ng] = 1'b1; ng++;
            end else if (acc_if_seen) begin
                seq[ng] = 1'b0; ng++;
                if (first_f < 0) first_f = t;
            end
            step();
            mem_rdata = $urandom;
            if (acc_d_seen) d_req_addr = d_req_addr + 32'h4;
            if (acc_if_seen) if_req_addr = if_req_addr + 32'h4;
            t++;
        end
        check("t3_grant_count", ng, 4);
`ifdef MEMARB_RR_EN
        check("t3_grant_seq", 32'(seq), 32'h5);
        check("t3_first_fetch", first_f, 3);
`else
        check("t3_grant_seq", 32'(seq), 32'hb);
        check("t3_first_fetch", first_f, 6);
`endif
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (6) step();

        // Reset during WAIT of a load
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h01000200;
        @(negedge clk); check("t4_accept", d_req_ready, 1'b1);
        step(); d_req_valid = 1'b0;
        step(); reset = 1'b1;
        step(); reset = 1'b0; d_req_valid = 1'b1; d_req_addr = 32'h01000300;
        @(negedge clk);
        check("t4_busy", busy, 1'b0); check("t4_d_rsp_valid", d_rsp_valid, 1'b0);
        check("t4_if_rsp_valid", if_rsp_valid, 1'b0); check("t4_mem_addr", mem_addr, 32'h0);
        check("t4_d_rsp_data", d_rsp_data, 32'h0); check("t4_fresh_ready", d_req_ready, 1'b1);
        step(); d_req_valid = 1'b0;
        repeat (4) step();

        // Randomized traffic with occasional reset; fields held while waiting
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            acc_if_seen = if_req_valid && if_req_ready;
            acc_d_seen  = d_req_valid && d_req_ready;
            step();
            reset = ($urandom_range(0, 79) == 0);
            if (!if_req_valid || acc_if_seen) begin
                if_req_valid = $urandom_range(0, 1);
                if_req_addr  = $urandom;
            end
            if (!d_req_valid || acc_d_seen) begin
                d_req_valid = $urandom_range(0, 1);
                d_req_we    = $urandom_range(0, 1);
                d_req_addr  = $urandom;
                d_req_wdata = $urandom;
                d_req_be    = 4'($urandom_range(0, 15));
            end
            mem_rdata = $urandom;
        end
        reset = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (10) step();

        // MEM_LAT=3 instance: back-to-back loads 0x0 then 0x4
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0; l3_d_valid = 1'b1; l3_d_addr = 32'h0; l3_mem_rdata = 32'ha0000000;
        ren_mask = 13'h0; rsp_mask = 13'h0; n3 = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (l3_mem_ren) ren_mask[k] = 1'b1;
            if (l3_d_rsp_valid) begin
                rsp_mask[k] = 1'b1;
                check("t6_rsp_data", l3_d_rsp_data, 32'ha0000000 + 32'(k - 1));
            end
            acc_d_seen = l3_d_valid && l3_d_ready;
            step();
            l3_mem_rdata = 32'ha0000000 + 32'(k + 1);
            if (acc_d_seen) begin
                n3++;
                if (n3 == 1) l3_d_addr = 32'h4;
                else l3_d_valid = 1'b0;
            end
        end
        check("t6_ren_cycles", 32'(ren_mask), 32'h042);
        check("t6_rsp_cycles", 32'(rsp_mask), 32'h420);
        check("t6_accepts", n3, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
